// File: rtl/burst_search_ctrl.sv
// burst_search_ctrl
// Sequencer between the burst peak finder and the host packetizer. A search
// window is armed over the settings bus; every flagged peak-finder result is
// turned into a two-word report packet {phase,offset} then {sample index}.
// A holdoff after each report, a burst-count limit and a window length bound
// the search, after which a one-cycle done pulse is raised.
//
// Stream handshakes: a transfer happens on a rising clock edge where valid
// and ready are both high. The producer holds data/last stable while valid is
// high and ready is low, and never drops valid before the transfer completes.
module burst_search_ctrl #(
    parameter logic [7:0]  SR_BASE     = 8'd0,
    parameter int unsigned HOLDOFF_RST = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        armed,
    output logic        done,
    output logic [7:0]  burst_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEARCH  = 3'd1,
        S_HOLDOFF = 3'd2,
        S_RPT0    = 3'd3,
        S_RPT1    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [15:0] HOLDOFF_INIT = 16'(HOLDOFF_RST);

    // Configuration registers
    logic [31:0] window_q, window_d;
    logic [7:0]  max_bursts_q, max_bursts_d;
    logic [15:0] holdoff_q, holdoff_d;

    // One-shot control strobes decoded from the settings bus
    logic        arm_stb;
    logic        abort_stb;

    // Sequencer state
    state_t      state_q, state_d;
    logic [31:0] sample_cnt_q, sample_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic [31:0] lat_data_q, lat_data_d;
    logic [31:0] lat_cnt_q, lat_cnt_d;
    logic        win_end_q, win_end_d;
    logic        abort_pend_q, abort_pend_d;

    // Helpers
    logic        beat;
    logic        counting;
    logic        at_win_end;
    logic [7:0]  burst_inc;

    // Input is refused only while a report packet is being emitted
    always_comb begin
        i_tready = 1'b1;
        if (state_q == S_RPT0 || state_q == S_RPT1) begin
            i_tready = 1'b0;
        end
    end

    // Beat qualification and window-end detection for the current beat
    always_comb begin
        beat       = i_tvalid & i_tready;
        counting   = (state_q == S_SEARCH) || (state_q == S_HOLDOFF);
        at_win_end = (window_q != 32'd0) && ((sample_cnt_q + 32'd1) == window_q);
        burst_inc  = burst_cnt_q + 8'd1;
    end

    // Settings-bus decode: stored config plus self-clearing arm/abort strobes
    always_comb begin
        window_d     = window_q;
        max_bursts_d = max_bursts_q;
        holdoff_d    = holdoff_q;
        arm_stb      = 1'b0;
        abort_stb    = 1'b0;
        if (set_stb) begin
            if (set_addr == SR_BASE) begin
                window_d = set_data;
            end
            if (set_addr == SR_BASE + 8'd1) begin
                max_bursts_d = set_data[7:0];
                holdoff_d    = set_data[31:16];
            end
            if (set_addr == SR_BASE + 8'd2) begin
                arm_stb   = set_data[0];
                abort_stb = set_data[1];
            end
        end
    end

    // Next-state logic: search, holdoff, report emission and completion
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        lat_data_d   = lat_data_q;
        lat_cnt_d    = lat_cnt_q;
        win_end_d    = win_end_q;
        abort_pend_d = abort_pend_q;

        // Beats are counted only while searching or holding off; the count
        // saturates rather than wrapping so a full-range window still ends.
        if (beat && counting && (sample_cnt_q != 32'hFFFF_FFFF)) begin
            sample_cnt_d = sample_cnt_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (arm_stb) begin
                    state_d      = S_SEARCH;
                    sample_cnt_d = 32'd0;
                    burst_cnt_d  = 8'd0;
                    win_end_d    = 1'b0;
                    abort_pend_d = 1'b0;
                end
            end

            S_SEARCH: begin
                if (abort_stb) begin
                    state_d = S_IDLE;
                end else if (beat) begin
                    if (i_tlast) begin
                        // A found flag on the window's last beat still gets
                        // reported; win_end finishes the search afterwards.
                        lat_data_d = i_tdata;
                        lat_cnt_d  = sample_cnt_q;
                        win_end_d  = at_win_end;
                        state_d    = S_RPT0;
                    end else if (at_win_end) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_HOLDOFF: begin
                if (abort_stb) begin
                    state_d = S_IDLE;
                end else if (beat) begin
                    if (at_win_end) begin
                        state_d = S_DONE;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 16'd1;
                        if (hold_cnt_q <= 16'd1) begin
                            state_d = S_SEARCH;
                        end
                    end
                end
            end

            S_RPT0: begin
                if (abort_stb) begin
                    abort_pend_d = 1'b1;
                end
                if (o_tready) begin
                    state_d = S_RPT1;
                end
            end

            S_RPT1: begin
                if (abort_stb) begin
                    abort_pend_d = 1'b1;
                end
                if (o_tready) begin
                    burst_cnt_d  = burst_inc;
                    win_end_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    if (abort_pend_q || abort_stb) begin
                        state_d = S_IDLE;
                    end else if (win_end_q ||
                                 ((max_bursts_q != 8'd0) && (burst_inc == max_bursts_q))) begin
                        state_d = S_DONE;
                    end else if (holdoff_q != 16'd0) begin
                        hold_cnt_d = holdoff_q;
                        state_d    = S_HOLDOFF;
                    end else begin
                        state_d = S_SEARCH;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // clear drops everything back to idle but keeps the configuration
        if (clear) begin
            state_d      = S_IDLE;
            sample_cnt_d = 32'd0;
            hold_cnt_d   = 16'd0;
            burst_cnt_d  = 8'd0;
            win_end_d    = 1'b0;
            abort_pend_d = 1'b0;
        end
    end

    // Report stream and status outputs, decoded from the registered state
    always_comb begin
        o_tvalid = 1'b0;
        o_tlast  = 1'b0;
        o_tdata  = 32'd0;
        case (state_q)
            S_RPT0: begin
                o_tvalid = 1'b1;
                o_tdata  = lat_data_q;
            end
            S_RPT1: begin
                o_tvalid = 1'b1;
                o_tlast  = 1'b1;
                o_tdata  = lat_cnt_q;
            end
            default: begin
                o_tvalid = 1'b0;
            end
        endcase
        armed       = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        burst_count = burst_cnt_q;
    end

    // State and configuration registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            window_q     <= 32'd0;
            max_bursts_q <= 8'd0;
            holdoff_q    <= HOLDOFF_INIT;
            state_q      <= S_IDLE;
            sample_cnt_q <= 32'd0;
            hold_cnt_q   <= 16'd0;
            burst_cnt_q  <= 8'd0;
            lat_data_q   <= 32'd0;
            lat_cnt_q    <= 32'd0;
            win_end_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            window_q     <= window_d;
            max_bursts_q <= max_bursts_d;
            holdoff_q    <= holdoff_d;
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            lat_data_q   <= lat_data_d;
            lat_cnt_q    <= lat_cnt_d;
            win_end_q    <= win_end_d;
            abort_pend_q <= abort_pend_d;
        end
    end

endmodule

// File: tb/tb_burst_search_ctrl.sv
// tb_burst_search_ctrl
// Randomized and directed stimulus for burst_search_ctrl. A beat-level
// reference model predicts the report words, done pulses and burst count;
// a monitor pops expected report words whenever a report transfer happens.
module tb_burst_search_ctrl;

    localparam logic [7:0] SR_BASE = 8'd0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        armed;
    logic        done;
    logic [7:0]  burst_count;

    burst_search_ctrl #(.SR_BASE(SR_BASE), .HOLDOFF_RST(64)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .armed(armed), .done(done), .burst_count(burst_count)
    );

    // Clock
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard: {tlast, tdata}
    logic [32:0] exp_q[$];

    // Reference model (beat level)
    logic [31:0] m_window;
    logic [7:0]  m_max;
    logic [15:0] m_hold;
    bit          m_active;
    bit          m_in_hold;
    int          m_hold_left;
    logic [31:0] m_cnt;
    logic [7:0]  m_bursts;
    int          exp_done = 0;
    int          dut_done = 0;

    bit          rdy_random = 1'b1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_window = 32'd0; m_max = 8'd0; m_hold = 16'd64;
        m_active = 1'b0; m_in_hold = 1'b0; m_hold_left = 0;
        m_cnt = 32'd0; m_bursts = 8'd0;
    endtask

    // One accepted input beat as seen by the specification's rules
    task automatic model_beat(input logic [31:0] d, input bit f);
        bit last;
        if (!m_active) return;
        last = (m_window != 0) && (m_cnt + 1 == m_window);
        if (!m_in_hold && f) begin
            exp_q.push_back({1'b0, d});
            exp_q.push_back({1'b1, m_cnt});
            m_cnt++;
            m_bursts++;
            if (last || (m_max != 0 && m_bursts == m_max)) begin
                m_active = 1'b0; exp_done++;
            end else if (m_hold != 0) begin
                m_in_hold = 1'b1; m_hold_left = int'(m_hold);
            end
        end else begin
            m_cnt++;
            if (last) begin
                m_active = 1'b0; exp_done++;
            end else if (m_in_hold) begin
                m_hold_left--;
                if (m_hold_left == 0) m_in_hold = 1'b0;
            end
        end
    endtask

    // Ready generator for the report stream
    always @(negedge clk) begin
        if (rdy_random) o_tready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops expected words on each report transfer, counts done
    // pulses and checks that a stalled word is held.
    initial begin
        bit          prev_stall = 1'b0;
        logic [32:0] prev_word = '0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (done) dut_done++;
                if (prev_stall) begin
                    check("stall_valid", {63'd0, o_tvalid}, 64'd1);
                    check("stall_word", {31'd0, o_tlast, o_tdata}, {31'd0, prev_word});
                end
                if (o_tvalid && o_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out_unexpected: got %0h expected no word", {o_tlast, o_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        check("out_word", {31'd0, o_tlast, o_tdata}, {31'd0, e});
                    end
                end
                prev_stall = o_tvalid && !o_tready;
                prev_word  = {o_tlast, o_tdata};
            end
        end
    end

    // Driver tasks: all start and end on a falling edge
    task automatic write_reg(input int off, input logic [31:0] d);
        set_stb = 1'b1; set_addr = SR_BASE + 8'(off); set_data = d;
        if (off == 0) m_window = d;
        if (off == 1) begin m_max = d[7:0]; m_hold = d[31:16]; end
        if (off == 2) begin
            if (d[1]) begin
                m_active = 1'b0; m_in_hold = 1'b0;
            end else if (d[0] && !m_active) begin
                m_active = 1'b1; m_in_hold = 1'b0; m_cnt = 0; m_bursts = 0;
            end
        end
        @(negedge clk);
        set_stb = 1'b0;
    endtask

    task automatic config_arm(input logic [31:0] win, input logic [7:0] mx, input logic [15:0] ho);
        write_reg(0, win);
        write_reg(1, {ho, 8'd0, mx});
        write_reg(2, 32'd1);
    endtask

    task automatic send_beat(input logic [31:0] d, input bit f, output int waited);
        i_tvalid = 1'b1; i_tdata = d; i_tlast = f; waited = 0;
        while (!i_tready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!i_tready) begin
            checks++; errors++;
            $display("FAIL beat_timeout: got ready=0 expected ready=1 within 300 cycles");
            i_tvalid = 1'b0; i_tlast = 1'b0;
            return;
        end
        model_beat(d, f);
        @(negedge clk);
        i_tvalid = 1'b0; i_tlast = 1'b0;
    endtask

    task automatic plain_beats(input int n);
        int w;
        for (int i = 0; i < n; i++) send_beat($urandom, 1'b0, w);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_tvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_search(input string nm);
        drain();
        if (m_active) begin
            write_reg(2, 32'd2);
            repeat (2) @(negedge clk);
        end
        check({nm, "_armed"}, {63'd0, armed}, 64'd0);
        check({nm, "_done_cnt"}, 64'(dut_done), 64'(exp_done));
        check({nm, "_bursts"}, {56'd0, burst_count}, {56'd0, m_bursts});
    endtask

    // Run a search sending total beats, flagging the listed beat indices
    task automatic run_flags(input string nm, input logic [31:0] win, input logic [7:0] mx,
                             input logic [15:0] ho, input int total,
                             input int f0, input int f1, input int f2);
        int w;
        bit f;
        config_arm(win, mx, ho);
        for (int i = 0; i < total; i++) begin
            f = (i == f0) || (i == f1) || (i == f2);
            send_beat({16'(i * 7), 16'(i)}, f, w);
        end
        finish_search(nm);
    endtask

    initial begin
        int w;
        reset_n = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        i_tdata = 32'd0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset values
        check("rst_o_tvalid", {63'd0, o_tvalid}, 64'd0);
        check("rst_o_tlast", {63'd0, o_tlast}, 64'd0);
        check("rst_o_tdata", {32'd0, o_tdata}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_armed", {63'd0, armed}, 64'd0);
        check("rst_bursts", {56'd0, burst_count}, 64'd0);
        check("rst_i_tready", {63'd0, i_tready}, 64'd1);

        // Window 100, one flag, done pulse right after the 100th beat
        config_arm(32'd100, 8'd0, 16'd0);
        plain_beats(10);
        send_beat(32'hABCD_1234, 1'b1, w);
        plain_beats(88);
        send_beat(32'h0, 1'b0, w);
        check("t1_done_pulse", {63'd0, done}, 64'd1);
        @(negedge clk);
        check("t1_done_single", {63'd0, done}, 64'd0);
        finish_search("t1");

        // Holdoff 5: middle flag falls in the holdoff and is ignored
        run_flags("t2", 32'd0, 8'd0, 16'd5, 40, 10, 12, 20);
        // Burst limit 2: third flag never reported
        run_flags("t3", 32'd0, 8'd2, 16'd0, 70, 3, 30, 60);
        // Flag on the window's last beat: report, then done, no holdoff
        run_flags("t4", 32'd50, 8'd0, 16'd4, 60, 49, -1, -1);
        // Window expiring inside a holdoff
        run_flags("t4b", 32'd20, 8'd0, 16'd10, 30, 15, -1, -1);

        // Latency: next beat accepted three cycles after a found beat
        rdy_random = 1'b0; o_tready = 1'b1;
        config_arm(32'd0, 8'd0, 16'd0);
        send_beat(32'h1111_2222, 1'b1, w);
        check("lat_valid_next", {63'd0, o_tvalid}, 64'd1);
        send_beat(32'h0, 1'b0, w);
        check("lat_next_beat_wait", 64'(w), 64'd2);

        // Stall in RPT0 for 7 cycles, abort during it
        o_tready = 1'b0;
        send_beat(32'h5A5A_0F0F, 1'b1, w);
        for (int i = 0; i < 7; i++) begin
            check("stall_rpt0_data", {32'd0, o_tdata}, {32'd0, 32'h5A5A_0F0F});
            check("stall_rpt0_ready", {63'd0, i_tready}, 64'd0);
            if (i == 3) write_reg(2, 32'd2);
            else @(negedge clk);
        end
        rdy_random = 1'b1;
        finish_search("t5");

        // Reset in the middle of RPT1
        rdy_random = 1'b0; o_tready = 1'b0;
        config_arm(32'd0, 8'd0, 16'd0);
        send_beat(32'hCAFE_0001, 1'b1, w);
        o_tready = 1'b1;
        @(negedge clk);
        o_tready = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_valid_after_rst", {63'd0, o_tvalid}, 64'd0);
        check("t6_bursts_after_rst", {56'd0, burst_count}, 64'd0);
        reset_n = 1'b1;
        exp_q.delete();
        model_reset();
        rdy_random = 1'b1;
        // Window is 0 after reset; re-arm while armed is ignored
        write_reg(2, 32'd1);
        plain_beats(120);
        send_beat(32'hBEEF_0002, 1'b1, w);
        write_reg(2, 32'd1);
        plain_beats(70);
        send_beat(32'hBEEF_0003, 1'b1, w);
        finish_search("t6");

        // clear during holdoff
        config_arm(32'd0, 8'd0, 16'd3);
        plain_beats(5);
        send_beat(32'h0C0C_0C0C, 1'b1, w);
        drain();
        clear = 1'b1;
        m_active = 1'b0; m_in_hold = 1'b0; m_cnt = 0; m_bursts = 0;
        @(negedge clk);
        clear = 1'b0;
        check("clr_armed", {63'd0, armed}, 64'd0);
        check("clr_bursts", {56'd0, burst_count}, 64'd0);
        finish_search("clr");

        // Randomized searches
        for (int s = 0; s < 25; s++) begin
            logic [31:0] win;
            logic [7:0]  mx;
            logic [15:0] ho;
            int          nb;
            win = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(15, 120));
            mx  = 8'($urandom_range(0, 3));
            ho  = 16'($urandom_range(0, 6));
            nb  = (win == 0) ? 60 : int'(win) + 10;
            config_arm(win, mx, ho);
            for (int i = 0; i < nb; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_beat($urandom, ($urandom_range(0, 7) == 0), w);
            end
            finish_search("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time limit
    initial begin
        #3000000;
        $display("FAIL global_timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule
